// File: rtl/breakout_pkg.sv
// Shared constants for the breakout game-flow controller:
// state encoding, board geometry and score width.
package breakout_pkg;

   localparam int BRICK_ROWS = 6;
   localparam int BRICK_COLS = 8;
   localparam int BRICK_N    = BRICK_ROWS * BRICK_COLS;
   localparam int SCORE_W    = 10;

   typedef logic [2:0] state_t;

   localparam state_t ST_ATTRACT = 3'd0;
   localparam state_t ST_NEW     = 3'd1;
   localparam state_t ST_READY   = 3'd2;
   localparam state_t ST_PLAY    = 3'd3;
   localparam state_t ST_PAUSE   = 3'd4;
   localparam state_t ST_OVER    = 3'd5;
   localparam state_t ST_WIN     = 3'd6;

endpackage

// File: rtl/breakout_btn_cond.sv
// Button conditioner: 2-flop sync, optional debounce filter
// (BREAKOUT_CTRL_DEBOUNCE_EN), then a registered rising-edge pulse.
import breakout_pkg::*;

module breakout_btn_cond
`ifdef BREAKOUT_CTRL_DEBOUNCE_EN
#(
   parameter int unsigned DEBOUNCE_CYCLES = 8
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   logic [1:0] sync_q;
   logic       level;
   logic       level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], btn};
      end
   end

`ifdef BREAKOUT_CTRL_DEBOUNCE_EN
   localparam int unsigned DB_N =
      (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam logic [31:0] DB_LAST = 32'(DB_N - 1);

   logic [31:0] db_cnt_q;
   logic        filt_q;

   // Filtered level follows only after DB_N differing samples in a row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q <= '0;
         filt_q   <= 1'b0;
      end else if (sync_q[1] == filt_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_q <= '0;
         filt_q   <= sync_q[1];
      end else begin
         db_cnt_q <= db_cnt_q + 32'd1;
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game-flow controller: attract, serve, play, pause, over/win,
// session high score. Optional BREAKOUT_CTRL_DEBOUNCE_EN filters buttons.
import breakout_pkg::*;

module breakout_game_ctrl #(
   parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
   parameter int unsigned SERVE_CYCLES    = CLK_FREQ_HZ,
   parameter int unsigned HOLD_CYCLES     = 2 * CLK_FREQ_HZ,
   parameter int unsigned BLINK_CYCLES    = CLK_FREQ_HZ / 4,
   parameter int unsigned DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_btn,
   input  logic               pause_btn,
   input  logic               ball_lost,
   input  logic [BRICK_N-1:0] bricks_alive,
   input  logic [SCORE_W-1:0] score,
   output logic               game_run,
   output logic               new_game,
   output logic [2:0]         state_o,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_high,
   output logic               blink
);

   if (CLK_FREQ_HZ < 1 || SERVE_CYCLES < 1 || HOLD_CYCLES < 1 ||
       BLINK_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("breakout_game_ctrl: cycle parameters must be >= 1");
   end

   localparam logic [31:0] SERVE_LD = 32'(SERVE_CYCLES - 1);
   localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] BLINK_LD = 32'(BLINK_CYCLES - 1);

   logic start_p;
   logic pause_p;

   breakout_btn_cond
`ifdef BREAKOUT_CTRL_DEBOUNCE_EN
   #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
   u_start (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (start_btn),
      .press   (start_p)
   );

   breakout_btn_cond
`ifdef BREAKOUT_CTRL_DEBOUNCE_EN
   #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
   u_pause (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (pause_btn),
      .press   (pause_p)
   );

   state_t             state_q;
   state_t             state_d;
   logic [31:0]        tmr_q;
   logic [31:0]        blk_cnt_q;
   logic               blink_q;
   logic [SCORE_W-1:0] high_q;
   logic               new_high_q;
   logic               game_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ATTRACT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ATTRACT: if (start_p) state_d = ST_NEW;
         ST_NEW:     state_d = ST_READY;
         ST_READY:   if (tmr_q == '0) state_d = ST_PLAY;
         ST_PLAY: begin
            if (bricks_alive == '0) state_d = ST_WIN;
            else if (ball_lost)     state_d = ST_OVER;
            else if (pause_p)       state_d = ST_PAUSE;
         end
         ST_PAUSE:   if (pause_p) state_d = ST_PLAY;
         ST_OVER,
         ST_WIN: begin
            if (tmr_q == '0 && start_p) state_d = ST_NEW;
         end
         default:    state_d = ST_ATTRACT;
      endcase
   end

   always_comb begin
      state_o    = state_q;
      new_game   = (state_q == ST_NEW);
      game_run   = (state_q == ST_PLAY);
      high_score = high_q;
      new_high   = new_high_q;
      blink      = blink_q;
   end

   assign game_end = (state_q == ST_PLAY) &&
                     (state_d == ST_OVER || state_d == ST_WIN);

   // One timer serves both the serve countdown and the end-screen hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_q <= '0;
      end else if (state_q == ST_NEW) begin
         tmr_q <= SERVE_LD;
      end else if (game_end) begin
         tmr_q <= HOLD_LD;
      end else if (tmr_q != '0) begin
         tmr_q <= tmr_q - 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         high_q     <= '0;
         new_high_q <= 1'b0;
      end else if (game_end) begin
         if (score > high_q) begin
            high_q     <= score;
            new_high_q <= 1'b1;
         end
      end else if (state_d == ST_NEW) begin
         new_high_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blk_cnt_q <= '0;
         blink_q   <= 1'b0;
      end else if (blk_cnt_q == BLINK_LD) begin
         blk_cnt_q <= '0;
         blink_q   <= ~blink_q;
      end else begin
         blk_cnt_q <= blk_cnt_q + 32'd1;
      end
   end

endmodule
